pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/rv32i_types.sv | 16 +
 rtl/sat_counter.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types.
//   rv32i_word     : 32-bit machine word (PCs, data)
//   rv32i_reg      : 5-bit architectural register index
//   hazard_state_t : state of the pipeline hazard controller
package rv32i_types;

    typedef logic [31:0] rv32i_word;
    typedef logic [4:0]  rv32i_reg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STALL      = 2'd1,
        REDIR_PEND = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : clock, rising edge
//   rst   : synchronous active-low clear
//   inc   : count enable for this cycle
//   count : current value, holds at all-ones
module sat_counter #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [width-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + width'(1);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller.
// Generates register load enables, bubble flushes and PC redirects from
// memory stalls, load-use hazards and branch redirects. A branch that
// resolves while memory is stalled is remembered and issued once the
// stall clears (the latest branch wins).
//   clk, rst            : clock, synchronous active-low reset
//   imem_*/dmem_*       : memory request/response handshakes
//   id_ex_mem_read/rd   : load flag and destination of ID/EX
//   if_id_rs1/rs2       : sources of IF/ID
//   br_taken/br_target  : redirect pulse and PC from EX
//   *_load, *_flush     : pipeline register control
//   pc_redirect(_target): PC mux select and target
//   stall_cycles        : cycles spent in memory stall
//   bubble_count        : bubbles injected into ID/EX
import rv32i_types::*;

module pipeline_hazard_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 imem_read,
    input  logic                 imem_resp,
    input  logic                 dmem_read,
    input  logic                 dmem_write,
    input  logic                 dmem_resp,
    input  logic                 id_ex_mem_read,
    input  rv32i_reg             id_ex_rd,
    input  rv32i_reg             if_id_rs1,
    input  rv32i_reg             if_id_rs2,
    input  logic                 br_taken,
    input  rv32i_word            br_target,
    output logic                 pc_load,
    output logic                 if_id_load,
    output logic                 id_ex_load,
    output logic                 ex_mem_load,
    output logic                 mem_wb_load,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 pc_redirect,
    output rv32i_word            pc_redirect_target,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] bubble_count
);

    hazard_state_t state_q, state_d;
    rv32i_word     pend_target_q;
    logic          mem_stall, load_use, redir_pend;

    assign mem_stall  = (imem_read & ~imem_resp) |
                        ((dmem_read | dmem_write) & ~dmem_resp);
    // A load into x0 never produces a value, so it cannot hazard.
    assign load_use   = id_ex_mem_read & (id_ex_rd != '0) &
                        ((id_ex_rd == if_id_rs1) | (id_ex_rd == if_id_rs2));
    assign redir_pend = (state_q == REDIR_PEND);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= RUN;
            pend_target_q <= '0;
        end else begin
            state_q <= state_d;
            // Covers both entry into REDIR_PEND and overwrite while in it.
            if (mem_stall && br_taken)
                pend_target_q <= br_target;
        end
    end

    always_comb begin
        state_d            = state_q;
        pc_load            = 1'b0;
        if_id_load         = 1'b0;
        id_ex_load         = 1'b0;
        ex_mem_load        = 1'b0;
        mem_wb_load        = 1'b0;
        if_id_flush        = 1'b0;
        id_ex_flush        = 1'b0;
        pc_redirect        = 1'b0;
        pc_redirect_target = '0;
        if (!rst) begin
            state_d = RUN;
        end else if (mem_stall) begin
            // Everything frozen; only decide whether a redirect is owed.
            if (!redir_pend)
                state_d = br_taken ? REDIR_PEND : STALL;
        end else if (redir_pend || br_taken) begin
            pc_load            = 1'b1;
            if_id_load         = 1'b1;
            id_ex_load         = 1'b1;
            ex_mem_load        = 1'b1;
            mem_wb_load        = 1'b1;
            if_id_flush        = 1'b1;
            id_ex_flush        = 1'b1;
            pc_redirect        = 1'b1;
            pc_redirect_target = redir_pend ? pend_target_q : br_target;
            state_d            = RUN;
        end else if (load_use) begin
            // Hold PC and IF/ID, drop a bubble into ID/EX.
            id_ex_load  = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
            state_d     = RUN;
        end else begin
            pc_load     = 1'b1;
            if_id_load  = 1'b1;
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
            state_d     = RUN;
        end
    end

    sat_counter #(.width(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mem_stall),
        .count (stall_cycles)
    );

    sat_counter #(.width(CNT_WIDTH)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (id_ex_flush),
        .count (bubble_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a vector table for the
// single-cycle decode, then hand sequences for stalls, pending redirects,
// reset and counter saturation. Counters built 3 bits wide so saturation
// is reachable.
import rv32i_types::*;

module tb_pipeline_hazard_ctrl;

    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            imem_read, imem_resp, dmem_read, dmem_write, dmem_resp;
    logic            id_ex_mem_read, br_taken;
    rv32i_reg        id_ex_rd, if_id_rs1, if_id_rs2;
    rv32i_word       br_target;
    logic            pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic            if_id_flush, id_ex_flush, pc_redirect;
    rv32i_word       pc_redirect_target;
    logic [CW-1:0]   stall_cycles, bubble_count;
    logic [7:0]      ctl;

    int checks = 0;
    int errors = 0;

    // ctl = {pc, if_id, id_ex, ex_mem, mem_wb loads, if_id_flush, id_ex_flush, redirect}
    localparam logic [7:0] C_RUN = 8'hF8, C_LU = 8'h3A, C_RED = 8'hFF, C_STL = 8'h00;

    assign ctl = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                  if_id_flush, id_ex_flush, pc_redirect};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .imem_read(imem_read), .imem_resp(imem_resp),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .br_taken(br_taken), .br_target(br_target),
        .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
        .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .pc_redirect(pc_redirect), .pc_redirect_target(pc_redirect_target),
        .stall_cycles(stall_cycles), .bubble_count(bubble_count)
    );

    typedef struct {
        logic       ir, irs, dr, dw, drs, mr;
        logic [4:0] rd, rs1, rs2;
        logic       br;
        logic [31:0] tgt;
        logic [7:0] exp_ctl;
        logic [31:0] exp_tgt;
        string      name;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        imem_read = 0; imem_resp = 0; dmem_read = 0; dmem_write = 0; dmem_resp = 0;
        id_ex_mem_read = 0; id_ex_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0;
        br_taken = 0; br_target = '0;
    endtask

    // Advance one edge; new inputs are then driven at posedge+1.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        cyc();
        cyc();
        rst = 1;
    endtask

    task automatic chk_out(input string name, input logic [7:0] ec, input logic [31:0] et);
        #1;
        check({name, "_ctl"}, 32'(ctl), 32'(ec));
        check({name, "_tgt"}, pc_redirect_target, et);
    endtask

    initial begin
        vecs[0]  = '{0,0,0,0,0, 0, 5'd0, 5'd0, 5'd0, 0, 32'h0,    C_RUN, 32'h0,    "idle"};
        vecs[1]  = '{0,0,0,0,0, 1, 5'd5, 5'd1, 5'd5, 0, 32'h0,    C_LU,  32'h0,    "lu_rs2"};
        vecs[2]  = '{0,0,0,0,0, 1, 5'd7, 5'd7, 5'd2, 0, 32'h0,    C_LU,  32'h0,    "lu_rs1"};
        vecs[3]  = '{0,0,0,0,0, 1, 5'd0, 5'd0, 5'd3, 0, 32'h0,    C_RUN, 32'h0,    "ld_x0"};
        vecs[4]  = '{0,0,0,0,0, 0, 5'd5, 5'd5, 5'd5, 0, 32'h0,    C_RUN, 32'h0,    "no_load"};
        vecs[5]  = '{0,0,0,0,0, 0, 5'd0, 5'd0, 5'd0, 1, 32'h1234, C_RED, 32'h1234, "br"};
        vecs[6]  = '{0,0,0,0,0, 1, 5'd9, 5'd9, 5'd0, 1, 32'hABC0, C_RED, 32'hABC0, "br_over_lu"};
        vecs[7]  = '{1,1,0,0,0, 0, 5'd0, 5'd0, 5'd0, 0, 32'h0,    C_RUN, 32'h0,    "imem_hit"};
        vecs[8]  = '{0,0,0,1,1, 0, 5'd0, 5'd0, 5'd0, 0, 32'h0,    C_RUN, 32'h0,    "dmem_hit"};
        vecs[9]  = '{0,0,0,1,0, 1, 5'd4, 5'd4, 5'd0, 0, 32'h0,    C_STL, 32'h0,    "dmem_stall"};
        vecs[10] = '{0,0,0,0,0, 0, 5'd0, 5'd0, 5'd0, 0, 32'h0,    C_RUN, 32'h0,    "after_stall"};

        // Reset state: outputs forced low while rst=0
        do_reset();
        rst = 0;
        chk_out("in_reset", C_STL, 32'h0);
        cyc();
        check("rst_state", 32'(dut.state_q), 32'(RUN));
        check("rst_stall_cnt", 32'(stall_cycles), 32'd0);
        check("rst_bubble_cnt", 32'(bubble_count), 32'd0);
        rst = 1;

        foreach (vecs[i]) begin
            imem_read = vecs[i].ir; imem_resp = vecs[i].irs;
            dmem_read = vecs[i].dr; dmem_write = vecs[i].dw; dmem_resp = vecs[i].drs;
            id_ex_mem_read = vecs[i].mr; id_ex_rd = vecs[i].rd;
            if_id_rs1 = vecs[i].rs1; if_id_rs2 = vecs[i].rs2;
            br_taken = vecs[i].br; br_target = vecs[i].tgt;
            chk_out(vecs[i].name, vecs[i].exp_ctl, vecs[i].exp_tgt);
            cyc();
        end
        check("tbl_stall_cnt", 32'(stall_cycles), 32'd1);
        check("tbl_bubble_cnt", 32'(bubble_count), 32'd4);

        // Load-use bubble counted once
        do_reset();
        check("lu_bub0", 32'(bubble_count), 32'd0);
        id_ex_mem_read = 1; id_ex_rd = 5; if_id_rs2 = 5;
        chk_out("lu_seq", C_LU, 32'h0);
        cyc();
        idle();
        check("lu_bub1", 32'(bubble_count), 32'd1);

        // Data-memory stall for three cycles, response in the fourth
        do_reset();
        dmem_read = 1;
        for (int c = 0; c < 3; c++) begin
            chk_out("dstall", C_STL, 32'h0);
            cyc();
            check("dstall_state", 32'(dut.state_q), 32'(STALL));
        end
        dmem_resp = 1;
        chk_out("dresp", C_RUN, 32'h0);
        cyc();
        check("dresp_state", 32'(dut.state_q), 32'(RUN));
        check("dstall_cnt", 32'(stall_cycles), 32'd3);
        // Saturation: six more stall cycles would reach 9 > 7
        dmem_resp = 0;
        for (int c = 0; c < 6; c++) cyc();
        check("sat_cnt", 32'(stall_cycles), 32'd7);
        idle();
        cyc();
        check("sat_hold", 32'(stall_cycles), 32'd7);

        // Redirect under instruction-memory stall
        do_reset();
        imem_read = 1; br_taken = 1; br_target = 32'h6000_0040;
        chk_out("rp_enter", C_STL, 32'h0);
        cyc();
        check("rp_state", 32'(dut.state_q), 32'(REDIR_PEND));
        br_taken = 0; br_target = 32'hDEAD_BEEF;
        chk_out("rp_wait", C_STL, 32'h0);
        cyc();
        imem_resp = 1;
        chk_out("rp_issue", C_RED, 32'h6000_0040);
        cyc();
        check("rp_state_run", 32'(dut.state_q), 32'(RUN));
        check("rp_bubble", 32'(bubble_count), 32'd1);
        idle();
        chk_out("rp_after", C_RUN, 32'h0);
        cyc();

        // Two redirects under stall: latest target wins, issued once
        do_reset();
        imem_read = 1; br_taken = 1; br_target = 32'h100;
        cyc();
        br_target = 32'h200;
        cyc();
        br_taken = 0; br_target = 32'h0; imem_resp = 1;
        chk_out("two_issue", C_RED, 32'h200);
        cyc();
        idle();
        chk_out("two_after", C_RUN, 32'h0);
        cyc();

        // Reset while a redirect is pending discards it
        do_reset();
        imem_read = 1; br_taken = 1; br_target = 32'h300;
        cyc();
        check("rr_state", 32'(dut.state_q), 32'(REDIR_PEND));
        br_taken = 0; rst = 0;
        chk_out("rr_in_reset", C_STL, 32'h0);
        cyc();
        check("rr_state_run", 32'(dut.state_q), 32'(RUN));
        check("rr_stall_cnt", 32'(stall_cycles), 32'd0);
        check("rr_bubble_cnt", 32'(bubble_count), 32'd0);
        rst = 1; idle();
        chk_out("rr_release", C_RUN, 32'h0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
